// File: rtl/tick_timer_scheduler.sv
// Four-channel countdown timer scheduler sharing one timebase prescaler.
// Channels are granted in round-robin order and get a one-cycle done pulse on completion.
//
// state | meaning
// IDLE  | no channel timed; picks next requester in round-robin order
// RUN   | counting ticks for the granted channel
// DONE  | one-cycle completion pulse for the served channel
module tick_timer_scheduler #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int DUR_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*DUR_W-1:0] dur,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic               tick,
    output logic               busy,
    output logic [DUR_W-1:0]   remaining
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       last_q, last_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       done_q, done_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [1:0]       sel;
    logic [1:0]       idx;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        found   = 1'b0;
        sel     = last_q;
        idx     = last_q;

        // Search starts just after the last served channel so a held request waits its turn.
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    ch_d    = sel;
                    last_d  = sel;
                    presc_d = '0;
                    rem_d   = dur[int'(sel)*DUR_W +: DUR_W];
                    state_d = (rem_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[ch_q]) begin
                    // Abort takes priority over a final tick landing in the same cycle.
                    state_d = IDLE;
                    rem_d   = '0;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    if (rem_q == DUR_W'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                rem_d   = '0;
                presc_d = '0;
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
                presc_d = '0;
            end
        endcase

        grant_d = (state_d == RUN)  ? (4'b0001 << ch_d) : 4'b0000;
        done_d  = (state_d == DONE) ? (4'b0001 << ch_d) : 4'b0000;
        tick_d  = (state_d == RUN) && (presc_d == PRESC_MAX);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            last_q  <= 2'd3;
            presc_q <= '0;
            rem_q   <= '0;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler with TICK_CYCLES = 4.
// Observed vector is {grant, done, tick, busy, remaining}.
module tb_tick_timer_scheduler;

    localparam int TC = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [4*DW-1:0] dur = '0;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            tick;
    logic            busy;
    logic [DW-1:0]   remaining;

    int checks = 0;
    int fails  = 0;
    logic [17:0] exp_v;
    wire  [17:0] obs = {grant, done, tick, busy, remaining};

    tick_timer_scheduler #(.TICK_CYCLES(TC), .DUR_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dur       (dur),
        .grant     (grant),
        .done      (done),
        .tick      (tick),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int c, input logic [DW-1:0] v);
        dur[c*DW +: DW] = v;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b0000;
        repeat (3) step();
        exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp_v);
        end
        #2 rst = 1'b1;
        step();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_idle got=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_single_run();
        set_dur(0, 8'd3);
        req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_v = {4'b0001, 4'b0000, 1'((c % 4) == 0), 1'b1, 8'(3 - (c - 1) / 4)};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL single_run c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        step();
        exp_v = {4'b0000, 4'b0001, 1'b0, 1'b1, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL single_done got=%b exp=%b", obs, exp_v);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL single_after c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        reset_pulse();
        for (int i = 0; i < 4; i++) set_dur(i, 8'd1);
        req = 4'b1111;
        for (int r = 0; r < 6; r++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                exp_v = {4'b0001 << (r % 4), 4'b0000, 1'(c == 4), 1'b1, 8'd1};
                checks++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL rr_grant r=%0d c=%0d got=%b exp=%b", r, c, obs, exp_v);
                end
            end
            step();
            exp_v = {4'b0000, 4'b0001 << (r % 4), 1'b0, 1'b1, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rr_done r=%0d got=%b exp=%b", r, obs, exp_v);
            end
            step();
            exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rr_gap r=%0d got=%b exp=%b", r, obs, exp_v);
            end
            if (r == 5) req = 4'b0000;
        end
        step();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL rr_quiet got=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_zero_dur();
        set_dur(2, 8'd0);
        req = 4'b0100;
        step();
        exp_v = {4'b0000, 4'b0100, 1'b0, 1'b1, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL zero_dur_done got=%b exp=%b", obs, exp_v);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL zero_dur_after c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        set_dur(1, 8'd5);
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_v = {4'b0010, 4'b0000, 1'(c == 4), 1'b1, (c <= 4) ? 8'd5 : 8'd4};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_run c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_clear c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        set_dur(0, 8'd1);
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_v = {4'b0001, 4'b0000, 1'(c == 4), 1'b1, 8'd1};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_next c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        step();
        exp_v = {4'b0000, 4'b0001, 1'b0, 1'b1, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL abort_next_done got=%b exp=%b", obs, exp_v);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_async_reset();
        set_dur(0, 8'd4);
        req = 4'b0001;
        repeat (3) step();
        exp_v = {4'b0001, 4'b0000, 1'b0, 1'b1, 8'd4};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL areset_pre got=%b exp=%b", obs, exp_v);
        end
        #3 rst = 1'b0;
        #1;
        exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL areset_immediate got=%b exp=%b", obs, exp_v);
        end
        req = 4'b1001;
        set_dur(0, 8'd2);
        set_dur(3, 8'd2);
        step();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL areset_held got=%b exp=%b", obs, exp_v);
        end
        #2 rst = 1'b1;
        step();
        exp_v = {4'b0001, 4'b0000, 1'b0, 1'b1, 8'd2};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL areset_first_ch0 got=%b exp=%b", obs, exp_v);
        end
        req = 4'b0000;
        step();
        exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL areset_abort got=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_dur_change();
        set_dur(0, 8'd2);
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_v = {4'b0001, 4'b0000, 1'((c % 4) == 0), 1'b1, 8'(2 - (c - 1) / 4)};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL dur_change_run c=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (c == 2) set_dur(0, 8'd7);
        end
        step();
        exp_v = {4'b0000, 4'b0001, 1'b0, 1'b1, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL dur_change_done got=%b exp=%b", obs, exp_v);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_abort_final_tick();
        set_dur(0, 8'd1);
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_v = {4'b0001, 4'b0000, 1'(c == 4), 1'b1, 8'd1};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_tick_run c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            exp_v = {4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_tick_nodone c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_round_robin();
        test_zero_dur();
        test_abort();
        test_async_reset();
        test_dur_change();
        test_abort_final_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
